// File: rtl/demux_1to2_reg_pkg.sv
// Shared constants for the 1:2 demux: default widths and select encodings.
// The select encodings match the ones used by the core's mux select generation.
package demux_1to2_reg_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_CNT_DEF  = 32;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  // A one-entry slot can take a new beat when it is empty or emptying this cycle.
  function automatic logic slot_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/demux_1to2_reg_if.sv
// Producer/consumer bundle for demux_1to2_reg. Counter signals exist only when
// the DEMUX_CNT_EN macro is defined.
interface demux_1to2_reg_if
  import demux_1to2_reg_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
`ifdef DEMUX_CNT_EN
  , parameter int NB_CNT = NB_CNT_DEF
`endif
) ();

  logic               i_valid;
  logic [NB_DATA-1:0] i_data;
  logic               i_sel;
  logic               o_ready;

  logic               o_valid_a;
  logic [NB_DATA-1:0] o_data_a;
  logic               i_ready_a;

  logic               o_valid_b;
  logic [NB_DATA-1:0] o_data_b;
  logic               i_ready_b;

`ifdef DEMUX_CNT_EN
  logic [NB_CNT-1:0]  o_cnt_a;
  logic [NB_CNT-1:0]  o_cnt_b;
`endif

  // Demux side.
  modport slave (
    input  i_valid, i_data, i_sel, i_ready_a, i_ready_b,
    output o_ready, o_valid_a, o_data_a, o_valid_b, o_data_b
`ifdef DEMUX_CNT_EN
    , output o_cnt_a, o_cnt_b
`endif
  );

  // Producer plus both consumers.
  modport master (
    output i_valid, i_data, i_sel, i_ready_a, i_ready_b,
    input  o_ready, o_valid_a, o_data_a, o_valid_b, o_data_b
`ifdef DEMUX_CNT_EN
    , input o_cnt_a, o_cnt_b
`endif
  );

endinterface

// File: rtl/demux_1to2_reg_pipe_slot.sv
// One-entry valid/data register: loads on i_load, clears valid on drain, and
// reports whether it can accept a beat this cycle.
module demux_1to2_reg_pipe_slot
  import demux_1to2_reg_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_free
);

  assign o_free = slot_free(o_valid, i_ready);

  // Load wins over drain so a simultaneous drain+load keeps valid high with no
  // bubble; a plain drain leaves the data register untouched.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so valid and data both update from pre-edge values.
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1to2_reg.sv
// Registered 1:2 demultiplexer with valid/ready flow control; one slot per channel.
// Optional per-channel drain counters are built when DEMUX_CNT_EN is defined.
module demux_1to2_reg
  import demux_1to2_reg_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
`ifdef DEMUX_CNT_EN
  , parameter int NB_CNT = NB_CNT_DEF
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst,
  demux_1to2_reg_if.slave    bus
);

  sel_e sel;
  logic free_a;
  logic free_b;
  logic accept;
  logic load_a;
  logic load_b;

  assign sel = sel_e'(bus.i_sel);

  // Ready follows the selected slot only, so a stalled channel never blocks the other.
  assign bus.o_ready = (sel == SEL_B) ? free_b : free_a;
  assign accept      = bus.i_valid && bus.o_ready;
  assign load_a      = accept && (sel == SEL_A);
  assign load_b      = accept && (sel == SEL_B);

  demux_1to2_reg_pipe_slot #(
    .NB_DATA (NB_DATA)
  ) u_slot_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load_a),
    .i_data  (bus.i_data),
    .i_ready (bus.i_ready_a),
    .o_valid (bus.o_valid_a),
    .o_data  (bus.o_data_a),
    .o_free  (free_a)
  );

  demux_1to2_reg_pipe_slot #(
    .NB_DATA (NB_DATA)
  ) u_slot_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load_b),
    .i_data  (bus.i_data),
    .i_ready (bus.i_ready_b),
    .o_valid (bus.o_valid_b),
    .o_data  (bus.o_data_b),
    .o_free  (free_b)
  );

`ifdef DEMUX_CNT_EN
  logic [NB_CNT-1:0] cnt_a;
  logic [NB_CNT-1:0] cnt_b;

  // Count delivered beats (consumer handshakes); wraps naturally at 2^NB_CNT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (bus.o_valid_a && bus.i_ready_a) cnt_a <= cnt_a + 1'b1;
      if (bus.o_valid_b && bus.i_ready_b) cnt_b <= cnt_b + 1'b1;
    end
  end

  assign bus.o_cnt_a = cnt_a;
  assign bus.o_cnt_b = cnt_b;
`endif

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Self-checking bench for demux_1to2_reg: scoreboard on both channels, a table of
// per-cycle ready/valid vectors, and hand-written corner-case sequences.
module tb_demux_1to2_reg;
  import demux_1to2_reg_pkg::*;

  localparam int NB_DATA = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef DEMUX_CNT_EN
  localparam int NB_CNT = 4;
  demux_1to2_reg_if #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) bus ();
  demux_1to2_reg #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );
`else
  demux_1to2_reg_if #(.NB_DATA(NB_DATA)) bus ();
  demux_1to2_reg #(.NB_DATA(NB_DATA)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );
`endif

  int errors = 0;
  int checks = 0;
  logic [NB_DATA-1:0] exp_a[$];
  logic [NB_DATA-1:0] exp_b[$];

  typedef struct {
    logic               valid;
    sel_e               sel;
    logic [NB_DATA-1:0] data;
    logic               ready_a;
    logic               ready_b;
    logic               exp_ready;
    logic               exp_valid_a;
    logic               exp_valid_b;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [NB_DATA-1:0] d,
                       input logic ra, input logic rb);
    bus.i_valid   = v;
    bus.i_sel     = s;
    bus.i_data    = d;
    bus.i_ready_a = ra;
    bus.i_ready_b = rb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on input handshake, pop and compare on each output handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (bus.o_valid_a && bus.i_ready_a) begin
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_a: got beat %h expected none", bus.o_data_a);
        end else begin
          check("sb_a", bus.o_data_a, exp_a.pop_front());
        end
      end
      if (bus.o_valid_b && bus.i_ready_b) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_b: got beat %h expected none", bus.o_data_b);
        end else begin
          check("sb_b", bus.o_data_b, exp_b.pop_front());
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        if (bus.i_sel == SEL_B) exp_b.push_back(bus.i_data);
        else                    exp_a.push_back(bus.i_data);
      end
    end
  end

  initial begin
    //                valid sel    data          ra    rb    rdy   va    vb
    vecs[0]  = '{1'b1, SEL_A, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, SEL_B, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, SEL_A, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, SEL_A, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, SEL_A, 32'hA0000001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, SEL_A, 32'hA0000002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, SEL_B, 32'hB0000001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, SEL_B, 32'hB0000002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, SEL_B, 32'hB0000002, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, SEL_A, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, SEL_A, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset held for two edges with a valid beat offered.
    rst = 1'b1;
    drive(1'b1, SEL_A, 32'hFFFFFFFF, 1'b1, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    check("rst_valid_a", bus.o_valid_a, 1'b0);
    check("rst_valid_b", bus.o_valid_b, 1'b0);
    check("rst_data_a", bus.o_data_a, 32'h0);
    check("rst_data_b", bus.o_data_b, 32'h0);
`ifdef DEMUX_CNT_EN
    check("rst_cnt_a", bus.o_cnt_a, 4'h0);
    check("rst_cnt_b", bus.o_cnt_b, 4'h0);
`endif
    tick();

    // Routing, single-cycle valids, backpressure and drain+load, one cycle per row.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ready_a, vecs[i].ready_b);
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), bus.o_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_valid_a", i), bus.o_valid_a, vecs[i].exp_valid_a);
      check($sformatf("vec%0d_valid_b", i), bus.o_valid_b, vecs[i].exp_valid_b);
      tick();
    end

    // A stalled for 10 cycles while B still accepts and delivers a beat.
    drive(1'b1, SEL_A, 32'hAAAA0001, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_load_ready", bus.o_ready, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) drive(1'b1, SEL_B, 32'hBBBB0001, 1'b0, 1'b1);
      else        drive(1'b1, SEL_A, 32'hAAAA0002, 1'b0, 1'b1);
      @(negedge clk);
      check($sformatf("bp%0d_ready", i), bus.o_ready, (i == 4) ? 1'b1 : 1'b0);
      check($sformatf("bp%0d_valid_a", i), bus.o_valid_a, 1'b1);
      check($sformatf("bp%0d_data_a", i), bus.o_data_a, 32'hAAAA0001);
      tick();
    end
    drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    check("bp_release_valid_a", bus.o_valid_a, 1'b1);
    tick();
    @(negedge clk);
    check("bp_after_valid_a", bus.o_valid_a, 1'b0);
    check("bp_hold_data_a", bus.o_data_a, 32'hAAAA0001);
    tick();

    // Eight back-to-back beats on A with no bubble.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, SEL_A, NB_DATA'(i), 1'b1, 1'b1);
      @(negedge clk);
      check($sformatf("tp%0d_ready", i), bus.o_ready, 1'b1);
      if (i > 1) begin
        check($sformatf("tp%0d_valid_a", i), bus.o_valid_a, 1'b1);
        check($sformatf("tp%0d_data_a", i), bus.o_data_a, 64'(i - 1));
      end
      tick();
    end
    drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    check("tp_last_data_a", bus.o_data_a, 32'h8);
    check("tp_last_valid_a", bus.o_valid_a, 1'b1);
    tick();
    @(negedge clk);
    check("tp_idle_valid_a", bus.o_valid_a, 1'b0);
    tick();

    // Reset pulse while A holds a stalled beat: the beat must never appear.
    drive(1'b1, SEL_A, 32'h55550001, 1'b0, 1'b0);
    tick();
    drive(1'b0, SEL_A, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_stalled_valid_a", bus.o_valid_a, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mid_rst%0d_valid_a", i), bus.o_valid_a, 1'b0);
      tick();
    end

`ifdef DEMUX_CNT_EN
    // Seventeen beats drained on B wrap the 4-bit counter to 1.
    rst = 1'b1;
    drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, SEL_B, NB_DATA'(32'hC000_0000 + i), 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, SEL_A, 32'h0, 1'b1, 1'b1);
    tick();
    tick();
    @(negedge clk);
    check("cnt_b_wrap", bus.o_cnt_b, 4'h1);
    check("cnt_a_idle", bus.o_cnt_a, 4'h0);
    tick();
`endif

    @(negedge clk);
    check("sb_a_empty", exp_a.size(), 0);
    check("sb_b_empty", exp_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
